// File: rtl/fir_deconv.sv
// rtl/fir_deconv.sv - inverse FIR: rebuilds x from y with one MAC per cycle
// Single multiplier walks taps 1..3 after loading y into the accumulator.
module fir_deconv #(
    parameter int XW           = 8,
    parameter int YW           = 16,
    parameter int CW           = 8,
    parameter int signed H1    = 2,
    parameter int signed H2    = -1,
    parameter int signed H3    = 3,
    parameter int SHIFT        = 0,
    parameter int AW           = YW + XW + 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hist_clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [YW-1:0] y_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [XW-1:0] x_out,
    output logic                 sat
);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    localparam logic signed [CW-1:0] C1   = CW'(H1);
    localparam logic signed [CW-1:0] C2   = CW'(H2);
    localparam logic signed [CW-1:0] C3   = CW'(H3);
    localparam logic signed [AW-1:0] XMAX = AW'((1 <<< (XW - 1)) - 1);
    localparam logic signed [AW-1:0] XMIN = ~XMAX;

    state_t                 state_q;
    logic signed [AW-1:0]   acc_q;
    logic [1:0]             k_q;
    logic signed [XW-1:0]   x1_q, x2_q, x3_q;
    logic signed [XW-1:0]   x_out_q;
    logic                   sat_q;
    logic                   in_ready_q;
    logic                   out_valid_q;

    logic signed [CW-1:0]    coef;
    logic signed [XW-1:0]    xsel;
    logic signed [CW+XW-1:0] prod;
    logic signed [AW-1:0]    prod_ext;
    logic signed [AW-1:0]    acc_d;
    logic signed [AW-1:0]    r;
    logic signed [XW-1:0]    x_d;
    logic                    sat_d;

    always_comb begin
        coef = C1;
        xsel = x1_q;
        case (k_q)
            2'd2: begin coef = C2; xsel = x2_q; end
            2'd3: begin coef = C3; xsel = x3_q; end
            default: ;
        endcase
    end

    assign prod     = coef * xsel;
    assign prod_ext = {{(AW-CW-XW){prod[CW+XW-1]}}, prod};
    assign acc_d    = acc_q - prod_ext;
    assign r        = acc_d >>> SHIFT;

    // Clip to the x range; the clipped value is also what enters the history.
    always_comb begin
        x_d   = r[XW-1:0];
        sat_d = 1'b0;
        if (r > XMAX) begin
            x_d   = XMAX[XW-1:0];
            sat_d = 1'b1;
        end else if (r < XMIN) begin
            x_d   = XMIN[XW-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            k_q         <= 2'd0;
            x1_q        <= '0;
            x2_q        <= '0;
            x3_q        <= '0;
            x_out_q     <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hist_clr) begin
                        x1_q <= '0;
                        x2_q <= '0;
                        x3_q <= '0;
                    end else if (in_valid) begin
                        acc_q      <= {{(AW-YW){y_in[YW-1]}}, y_in};
                        k_q        <= 2'd1;
                        in_ready_q <= 1'b0;
                        state_q    <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (k_q == 2'd3) begin
                        k_q         <= 2'd0;
                        x_out_q     <= x_d;
                        sat_q       <= sat_d;
                        x1_q        <= x_d;
                        x2_q        <= x1_q;
                        x3_q        <= x2_q;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x_out     = x_out_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_fir_deconv.sv
// tb/tb_fir_deconv.sv - table, corner-case and random checks of fir_deconv
// Reference model recomputes each x from the recurrence with plain integers.
module tb_fir_deconv;

    localparam int H1 = 2, H2 = -1, H3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              rst_n, hist_clr, in_valid, out_ready;
    logic              in_ready, out_valid, sat;
    logic signed [15:0] y_in;
    logic signed [7:0]  x_out;

    logic              hist_clr_b, in_valid_b, out_ready_b;
    logic              in_ready_b, out_valid_b, sat_b;
    logic signed [15:0] y_in_b;
    logic signed [7:0]  x_out_b;

    fir_deconv dut (
        .clk(clk), .rst_n(rst_n), .hist_clr(hist_clr),
        .in_valid(in_valid), .in_ready(in_ready), .y_in(y_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .sat(sat)
    );

    fir_deconv #(.SHIFT(1)) dut_sh (
        .clk(clk), .rst_n(rst_n), .hist_clr(hist_clr_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .y_in(y_in_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .x_out(x_out_b), .sat(sat_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // hist[0] = x[n-1], hist[1] = x[n-2], hist[2] = x[n-3]
    int hist[3];

    task automatic model_clear();
        for (int i = 0; i < 3; i++) hist[i] = 0;
    endtask

    task automatic model(input int y, input int shift, output int x, output int s);
        int acc;
        acc = y - H1 * hist[0] - H2 * hist[1] - H3 * hist[2];
        acc = acc >>> shift;
        s = 0;
        x = acc;
        if (acc > 127) begin x = 127; s = 1; end
        else if (acc < -128) begin x = -128; s = 1; end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = x;
    endtask

    // Enters and leaves at a falling edge; lat counts edges from acceptance (inclusive) to out_valid.
    task automatic xact(input int y, input int stall, output int x, output int s,
                        output int lat, output int acc_cyc);
        int n;
        int held;
        x = 0; s = 0; lat = 0; acc_cyc = 0;
        y_in      = 16'(y);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        lat = 1;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin @(negedge clk); lat++; n++; end
        if (!out_valid) begin
            check("out_timeout", 0, 1);
            return;
        end
        x = int'(x_out);
        s = int'(sat);
        held = x;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_x_stable", int'(x_out), held);
            check("stall_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        int y;
        int ex;
        int es;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int x, s, lat, ac, prev_ac, ex, es, pulses, held, n;

        tbl[0] = '{-3,   -3,   0};
        tbl[1] = '{-5,    1,   0};
        tbl[2] = '{ 5,    0,   0};
        tbl[3] = '{-12,  -2,   0};
        tbl[4] = '{200,  127,  1};
        tbl[5] = '{-300, -128, 1};
        tbl[6] = '{0,    127,  1};

        rst_n = 1'b0; hist_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; y_in = '0;
        hist_clr_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b1; y_in_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();

        check("rst_in_ready",  int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_x_out",     int'(x_out), 0);
        check("rst_sat",       int'(sat), 0);

        xact(0, 0, x, s, lat, ac);
        model(0, 0, ex, es);
        check("zero_x", x, 0);
        check("zero_latency", lat, 4);

        prev_ac = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) begin
                // Clear wins over a simultaneous sample, which must not be taken.
                hist_clr = 1'b1; in_valid = 1'b1; y_in = 16'sd77;
                @(posedge clk);
                @(negedge clk);
                hist_clr = 1'b0; in_valid = 1'b0;
                check("clr_in_ready", int'(in_ready), 1);
                pulses = 0;
                repeat (5) begin @(negedge clk); if (out_valid) pulses++; end
                check("clr_no_accept", pulses, 0);
                model_clear();
            end
            xact(tbl[i].y, 0, x, s, lat, ac);
            model(tbl[i].y, 0, ex, es);
            check($sformatf("tbl%0d_x", i), x, tbl[i].ex);
            check($sformatf("tbl%0d_sat", i), s, tbl[i].es);
            check($sformatf("tbl%0d_model", i), x, ex);
            if (i >= 1 && i <= 3) check($sformatf("tbl%0d_period", i), ac - prev_ac, 5);
            prev_ac = ac;
        end

        // Backpressure: result held, upstream blocked while a new sample waits.
        model(3, 0, ex, es);
        y_in = 16'sd3; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        y_in = 16'sd9;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        check("bp_out_valid", int'(out_valid), 1);
        check("bp_x", int'(x_out), ex);
        check("bp_sat", int'(sat), es);
        held = int'(x_out);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_x_stable", int'(x_out), held);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_valid_held", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_out_valid", int'(out_valid), 0);

        for (int i = 0; i < 40; i++) begin
            int yr, st;
            if ($urandom_range(0, 3) == 0) begin
                hist_clr = 1'b1;
                @(posedge clk);
                @(negedge clk);
                hist_clr = 1'b0;
                model_clear();
            end
            yr = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 600)) - 300
                                           : int'($urandom_range(0, 60)) - 30;
            st = $urandom_range(0, 3);
            xact(yr, st, x, s, lat, ac);
            model(yr, 0, ex, es);
            check($sformatf("rnd%0d_x(y=%0d)", i, yr), x, ex);
            check($sformatf("rnd%0d_sat", i), s, es);
            check($sformatf("rnd%0d_lat", i), lat, 4);
        end

        y_in_b = -16'sd7; in_valid_b = 1'b1;
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid_b && n < 20) begin @(negedge clk); n++; end
        check("shift_valid", int'(out_valid_b), 1);
        check("shift_x", int'(x_out_b), -4);
        check("shift_sat", int'(sat_b), 0);
        @(negedge clk);

        // Reset during MAC drops the sample and wipes history.
        y_in = -16'sd3; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        pulses = 0;
        repeat (2) begin @(posedge clk); @(negedge clk); if (out_valid) pulses++; end
        rst_n = 1'b1;
        model_clear();
        repeat (8) begin @(negedge clk); if (out_valid) pulses++; end
        check("midrst_no_output", pulses, 0);
        xact(1, 0, x, s, lat, ac);
        model(1, 0, ex, es);
        check("midrst_x", x, 1);
        check("midrst_model", x, ex);
        check("midrst_sat", s, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
